// File: rtl/qspi_pkg.sv
// rtl/qspi_pkg.sv - shared types and constants for the QSPI transmit shifter
package qspi_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 5;

  // Lane mode as captured at load time
  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_QUAD   = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Index of the final beat of a word: 2*(len+1)-1 in quad mode, 8*(len+1)-1 in single mode.
  // Storing the last index rather than the beat count keeps a 32-beat word inside 5 bits.
  function automatic logic [CNT_W-1:0] last_beat_idx(input logic [1:0] len, input logic quad);
    if (quad == MODE_QUAD) begin
      return {2'b00, len, 1'b1};
    end
    return {len, 3'b111};
  endfunction

endpackage

// File: rtl/qspi_tx_shift_if.sv
// rtl/qspi_tx_shift_if.sv - load handshake and serial lane bundle for the QSPI transmit shifter
interface qspi_tx_shift_if;
  import qspi_pkg::*;

  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;
  logic [1:0]        len;
  logic              lsb_first;
  logic              quad;
  logic [3:0]        qsd;
  logic [3:0]        qsd_oe;
  logic              busy;
  logic              last;
  logic              done;

  // Word source side
  modport master (
    output data, valid, len, lsb_first, quad,
    input  ready, qsd, qsd_oe, busy, last, done
  );

  // Shifter side
  modport slave (
    input  data, valid, len, lsb_first, quad,
    output ready, qsd, qsd_oe, busy, last, done
  );

endinterface

// File: rtl/qspi_beat_cnt.sv
// rtl/qspi_beat_cnt.sv - beat counter with final-beat detection for one shifted word
module qspi_beat_cnt
  import qspi_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       run_i,
  input  logic [1:0] len_i,
  input  logic       quad_i,
  output logic       last_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] last_idx_q, last_idx_d;

  assign last_o = run_i && (cnt_q == last_idx_q);

  // Restart on every load (including one on the final beat); otherwise advance until the last index
  always_comb begin
    cnt_d      = cnt_q;
    last_idx_d = last_idx_q;
    if (start_i) begin
      cnt_d      = '0;
      last_idx_d = last_beat_idx(len_i, quad_i);
    end else if (run_i) begin
      cnt_d = last_o ? '0 : cnt_q + 5'd1;
    end
  end

  // Counter and word-length registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      last_idx_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      last_idx_q <= last_idx_d;
    end
  end

endmodule

// File: rtl/qspi_tx_shift.sv
// rtl/qspi_tx_shift.sv - QSPI transmit shifter, quad nibble or single bit beats
module qspi_tx_shift
  import qspi_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [1:0]        len_i,
  input  logic              lsb_first_i,
  input  logic              quad_i,
  output logic [3:0]        qsd_o,
  output logic [3:0]        qsd_oe_o,
  output logic              busy_o,
  output logic              last_o,
  output logic              done_o
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic              lsb_q, lsb_d;
  logic              quad_q, quad_d;
  logic              done_q, done_d;
  logic              load;
  logic              beat_last;
  logic              shifting;
  logic [4:0]        align_sh;

  assign shifting = (state_q == ST_SHIFT);
  assign load     = valid_i && ready_o;
  // MSB-first words are left-justified so the first beat is always at the top of the register
  assign align_sh = {2'd3 - len_i, 3'b000};

  qspi_beat_cnt u_beat_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (load),
    .run_i   (shifting),
    .len_i   (len_i),
    .quad_i  (quad_i),
    .last_o  (beat_last)
  );

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      lsb_q   <= 1'b0;
      quad_q  <= MODE_SINGLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      lsb_q   <= lsb_d;
      quad_q  <= quad_d;
      done_q  <= done_d;
    end
  end

  // Next state: a load always enters SHIFT; the final beat without a load falls back to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (load) state_d = ST_SHIFT;
      ST_SHIFT: if (beat_last && !load) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Capture on load, then move the register one beat per cycle toward the output end
  always_comb begin
    sr_d   = sr_q;
    lsb_d  = lsb_q;
    quad_d = quad_q;
    done_d = shifting && beat_last;
    if (load) begin
      sr_d   = lsb_first_i ? data_i : (data_i << align_sh);
      lsb_d  = lsb_first_i;
      quad_d = quad_i;
    end else if (shifting) begin
      if (beat_last) begin
        sr_d = '0;
      end else if (quad_q == MODE_QUAD) begin
        sr_d = lsb_q ? (sr_q >> 4) : (sr_q << 4);
      end else begin
        sr_d = lsb_q ? (sr_q >> 1) : (sr_q << 1);
      end
    end
  end

  // Outputs: idle values by default, lane data and enables while shifting
  always_comb begin
    ready_o  = 1'b1;
    busy_o   = 1'b0;
    last_o   = 1'b0;
    qsd_o    = 4'h0;
    qsd_oe_o = 4'h0;
    done_o   = done_q;
    if (shifting) begin
      ready_o = beat_last;
      busy_o  = 1'b1;
      last_o  = beat_last;
      if (quad_q == MODE_QUAD) begin
        qsd_oe_o = 4'hF;
        qsd_o    = lsb_q ? sr_q[3:0] : sr_q[DATA_W-1 -: 4];
      end else begin
        qsd_oe_o = 4'h1;
        qsd_o    = {3'b000, (lsb_q ? sr_q[0] : sr_q[DATA_W-1])};
      end
    end
  end

endmodule
